// File: rtl/decoder_3_8.sv
// ============================================================================
//  Module      : decoder_3_8
//  Description : 3-to-8 binary-to-one-hot decoder. Provides a combinational
//                decode (y) for glue logic and an enable-gated registered
//                copy (y_q) with a valid flag for pipelined consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_3_8 #(
    parameter logic [7:0] Y_Q_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] y,
    output logic [7:0] y_q,
    output logic       y_q_vld
);

    // Pure one-hot decode of the select code; no storage, depends on a only.
    always_comb begin
        y    = 8'h00;
        y[a] = 1'b1;
    end

    // Capture the decode when enabled; the valid flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= Y_Q_RESET;
            y_q_vld <= 1'b0;
        end else if (en) begin
            y_q     <= y;
            y_q_vld <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decoder_3_8.sv
// ============================================================================
//  Module      : tb_decoder_3_8
//  Description : Self-checking bench for decoder_3_8. A behavioural model
//                (shift-based decode plus a sticky capture) is compared against
//                the DUT on every falling clock edge; directed vectors carry
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_3_8;

    logic       clk;
    logic       rst_n;
    logic [2:0] a;
    logic       en;
    logic [7:0] y;
    logic [7:0] y_q;
    logic       y_q_vld;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_q;
    logic       m_vld;

    // Hand-computed one-hot table, LSB = bit 0
    logic [7:0] lits [8];

    decoder_3_8 #(.Y_Q_RESET(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .en      (en),
        .y       (y),
        .y_q     (y_q),
        .y_q_vld (y_q_vld)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the registered copy is the decode of a captured at enabled edges,
    // cleared immediately by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= 8'h00;
            m_vld <= 1'b0;
        end else if (en) begin
            m_q   <= 8'd1 << a;
            m_vld <= 1'b1;
        end
    end

    // Continuous comparison on the falling edge, away from capture edges.
    always @(negedge clk) begin
        chk("cmp_y", y, 8'd1 << a);
        chk("cmp_y_q", y_q, m_q);
        chk("cmp_y_q_vld", {7'd0, y_q_vld}, {7'd0, m_vld});
        if (y_q_vld === 1'b1) begin
            checks++;
            if (!$onehot(y_q)) begin
                errors++;
                $display("FAIL onehot_y_q: got %h expected one-hot at t=%0t", y_q, $time);
            end
        end
    end

    initial begin
        lits[0] = 8'h01; lits[1] = 8'h02; lits[2] = 8'h04; lits[3] = 8'h08;
        lits[4] = 8'h10; lits[5] = 8'h20; lits[6] = 8'h40; lits[7] = 8'h80;

        rst_n = 1'b0;
        en    = 1'b0;
        a     = 3'd0;

        // Combinational sweep, en = 0, reset held
        #2;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            #1;
            chk("sweep_y", y, lits[i]);
            #9;
        end

        // Reset held while clocking with en = 1, a = 5
        en = 1'b1;
        a  = 3'b101;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_y_q", y_q, 8'h00);
            chk("rst_vld", {7'd0, y_q_vld}, 8'h00);
            chk("rst_y", y, 8'h20);
        end

        // Capture latency: release reset, a = 3, en = 1 at next edge
        @(posedge clk); #2;
        rst_n = 1'b1;
        a     = 3'b011;
        en    = 1'b1;
        #1;
        chk("lat_before_y_q", y_q, 8'h00);
        chk("lat_before_vld", {7'd0, y_q_vld}, 8'h00);
        @(posedge clk); #1;
        chk("lat_after_y_q", y_q, 8'h08);
        chk("lat_after_vld", {7'd0, y_q_vld}, 8'h01);

        // Hold: capture a = 6, then en = 0 with a = 1 for 3 cycles
        #1;
        a = 3'b110;
        @(posedge clk); #1;
        chk("hold_cap_y_q", y_q, 8'h40);
        #1;
        en = 1'b0;
        a  = 3'b001;
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_y_q", y_q, 8'h40);
            chk("hold_vld", {7'd0, y_q_vld}, 8'h01);
            chk("hold_y", y, 8'h02);
        end

        // Async reset mid-stream between clock edges
        #1;
        a  = 3'b111;
        en = 1'b1;
        @(posedge clk); #1;
        chk("async_pre_y_q", y_q, 8'h80);
        en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_y_q", y_q, 8'h00);
        chk("async_vld", {7'd0, y_q_vld}, 8'h00);
        #1;
        rst_n = 1'b1;

        // Streaming: a = 0..7 on consecutive enabled edges
        @(posedge clk); #2;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            @(posedge clk); #1;
            chk("stream_y_q", y_q, lits[i]);
            chk("stream_vld", {7'd0, y_q_vld}, 8'h01);
            #1;
        end

        en = 1'b0;
        repeat (3) @(posedge clk);
        #6;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder_3_8.md
Name: decoder_3_8

Overview:
- 3-to-8 binary-to-one-hot decoder. A 3-bit code on a drives exactly one of eight outputs high.
- Provides a purely combinational output y for glue logic.
- Also provides a registered, enable-gated copy y_q with a valid flag, so pipelined consumers can take a clean, flop-aligned select.
- Sits between address/select generation and per-line enables (e.g. register-file write strobes, mux selects).

Parameters:
- Y_Q_RESET, 8'h00, value loaded into y_q on reset. Any 8-bit value is legal; the default is all lines deasserted.

Ports:
- clk  input  1  rising-edge clock for the registered path only
- rst_n  input  1  asynchronous active-low reset for the registered path
- a  input  3  binary select code, unsigned 0..7
- en  input  1  capture enable for the registered path
- y  output  8  combinational one-hot decode of a
- y_q  output  8  registered one-hot decode of a
- y_q_vld  output  1  high when y_q holds a captured decode, not the reset value

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Combinational path:
  - y[i] = 1 iff a == i, for i = 0..7; all other bits 0.
  - Exactly one bit of y is high for every legal a.
  - y depends only on a: no dependence on clk, rst_n or en.
  - No storage, zero-cycle latency; y settles within the same delta/propagation window as a changes.
- Mapping (LSB = bit 0):
  - 000 -> 0000_0001, 001 -> 0000_0010, 010 -> 0000_0100, 011 -> 0000_1000
  - 100 -> 0001_0000, 101 -> 0010_0000, 110 -> 0100_0000, 111 -> 1000_0000
- Registered path:
  - While rst_n = 0: y_q = Y_Q_RESET and y_q_vld = 0, immediately and independent of clk.
  - Reset assertion mid-operation clears both at once.
  - On each rising clk with rst_n = 1 and en = 1: y_q <= decode(a), y_q_vld <= 1. Latency is 1 cycle from a to y_q.
  - On a rising clk with en = 0: y_q and y_q_vld hold their values.
  - Reset release takes effect at the first rising clk after rst_n goes high. A capture at that edge is permitted if en = 1.
  - Once set, y_q_vld stays 1 until the next reset. en = 0 does not clear it.
- Boundary conditions:
  - a wraps naturally over 0..7; there are no out-of-range codes.
  - a changing in the same cycle en rises: the value sampled at the edge is captured.
  - Back-to-back en with changing a: y_q follows a one cycle delayed, with no dropped or duplicated cycles.
- Invariant: y_q is always one-hot or Y_Q_RESET. A bench assertion checks $onehot(y_q) whenever y_q_vld = 1.
- Fully synthesizable. No latches; no inferred storage on y.

Test Plan:
- Combinational sweep: drive a = 0..7, 10 time units apart, with en = 0 and rst_n at either level -> y equals 8'h01, 02, 04, 08, 10, 20, 40, 80 respectively. Check with === so X/Z counts as a failure.
- Reset: hold rst_n = 0 while toggling clk and en = 1 with a = 3'b101 -> y_q = 8'h00, y_q_vld = 0; y = 8'h20 throughout.
- Capture latency: release reset, then a = 3'b011, en = 1 at edge k -> y_q = 8'h08 and y_q_vld = 1 after edge k, not before.
- Hold: after capturing a = 3'b110 (y_q = 8'h40), set en = 0 and change a to 3'b001 for 3 cycles -> y_q stays 8'h40, y_q_vld stays 1, y = 8'h02.
- Async reset mid-stream: with y_q = 8'h80, pulse rst_n low between clock edges -> y_q = 8'h00 and y_q_vld = 0 before the next edge.
- Streaming: en = 1, a = 0,1,...,7 on consecutive edges -> y_q walks 8'h01 through 8'h80 one cycle behind a, and is one-hot every cycle.
